// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state type
// and the default HALT opcode.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [7:0] DEFAULT_HALT_OPCODE = 8'hFF;

endpackage : instr_fetch_ctrl_pkg

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the combinational
// instruction RAM and hands registered words to the decoder via valid/ready.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       MEM_DEPTH   = 128,
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(DEFAULT_HALT_OPCODE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              busy,
  output logic              halted,
  output logic              err_oob
);

  localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

  fetch_state_e state, state_next;

  // One extra bit so that an increment past the top of the address space
  // is still seen as out of range rather than wrapping to 0.
  logic [ADDR_W:0] pc;
  logic            oob;
  logic            handshake;

  assign oob       = (pc >= PC_LIMIT);
  assign handshake = (state == ST_ISSUE) && instr_ready;

  assign mem_en   = (state == ST_FETCH);
  assign mem_addr = pc[ADDR_W-1:0];
  assign busy     = (state == ST_FETCH) || (state == ST_ISSUE);
  assign halted   = (state == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_HALTED: if (start) state_next = ST_FETCH;
        ST_FETCH:           state_next = oob ? ST_HALTED : ST_ISSUE;
        ST_ISSUE: begin
          if (handshake) state_next = (instr == HALT_OPCODE) ? ST_HALTED : ST_FETCH;
        end
        default:            state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      err_oob     <= 1'b0;
    end else if (stop) begin
      instr_valid <= 1'b0;
      err_oob     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            pc      <= {1'b0, start_addr};
            err_oob <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (oob) begin
            err_oob <= 1'b1;
          end else begin
            instr       <= mem_data;
            instr_pc    <= pc[ADDR_W-1:0];
            instr_valid <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (instr != HALT_OPCODE) begin
              pc <= jump_valid ? {1'b0, jump_addr} : pc + (ADDR_W+1)'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule : instr_fetch_ctrl

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a transaction-level reference model.
module tb_instr_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, jump_valid, instr_ready;
  logic [7:0] start_addr, jump_addr;
  logic [7:0] mem_addr, mem_data, instr, instr_pc;
  logic       mem_en, instr_valid, busy, halted, err_oob;

  logic [7:0] mem [256];
  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128), .HALT_OPCODE(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .stop(stop), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .busy(busy), .halted(halted), .err_oob(err_oob)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: "what is the core doing" flags plus the word on offer.
  int         m_pc;
  bit         m_fetching, m_offering, m_stopped_at_halt;
  bit         e_valid, e_err;
  logic [7:0] e_instr, e_ipc;

  task automatic model_reset();
    m_pc = 0; m_fetching = 0; m_offering = 0; m_stopped_at_halt = 0;
    e_valid = 0; e_err = 0; e_instr = 0; e_ipc = 0;
  endtask

  task automatic model_edge();
    if (stop) begin
      m_fetching = 0; m_offering = 0; m_stopped_at_halt = 0;
      e_valid = 0; e_err = 0;
    end else if (start && !m_fetching && !m_offering) begin
      m_pc = int'(start_addr); e_err = 0;
      m_fetching = 1; m_stopped_at_halt = 0;
    end else if (m_fetching) begin
      m_fetching = 0;
      if (m_pc >= 128) begin
        e_err = 1; m_stopped_at_halt = 1;
      end else begin
        e_instr = mem[m_pc]; e_ipc = 8'(m_pc); e_valid = 1; m_offering = 1;
      end
    end else if (m_offering && instr_ready) begin
      m_offering = 0; e_valid = 0;
      if (e_instr == 8'hFF) m_stopped_at_halt = 1;
      else begin
        m_fetching = 1;
        m_pc = jump_valid ? int'(jump_addr) : m_pc + 1;
      end
    end
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".mem_en"},      32'(mem_en),      32'(m_fetching));
    check({ctx, ".mem_addr"},    32'(mem_addr),    32'(m_pc % 256));
    check({ctx, ".busy"},        32'(busy),        32'(m_fetching || m_offering));
    check({ctx, ".halted"},      32'(halted),      32'(m_stopped_at_halt));
    check({ctx, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
    check({ctx, ".instr"},       32'(instr),       32'(e_instr));
    check({ctx, ".instr_pc"},    32'(instr_pc),    32'(e_ipc));
    check({ctx, ".err_oob"},     32'(err_oob),     32'(e_err));
  endtask

  task automatic step(input string ctx, input bit s, input logic [7:0] sa, input bit sp,
                      input bit jv, input logic [7:0] ja, input bit rdy);
    @(negedge clk);
    start = s; start_addr = sa; stop = sp; jump_valid = jv; jump_addr = ja; instr_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ctx);
  endtask

  task automatic idle_cycles(input string ctx, input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(ctx, 0, 8'h00, 0, 0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; jump_valid = 0; instr_ready = 0;
    start_addr = 0; jump_addr = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h04;
    mem[3] = 8'hFF;
    model_reset();

    do_reset();

    // Straight run 0..3 ending on the HALT opcode.
    step("t1", 1, 8'd0, 0, 0, 8'd0, 1);
    idle_cycles("t1", 10, 1);
    check("t1_halted_final", 32'(halted), 32'd1);

    // Decoder stalls for 5 cycles on the first word.
    step("t2", 1, 8'd0, 0, 0, 8'd0, 0);
    idle_cycles("t2", 6, 0);
    check("t2_hold_pc", 32'(instr_pc), 32'd0);
    idle_cycles("t2", 10, 1);

    // Jump to 2 on the first handshake.
    step("t3", 1, 8'd0, 0, 0, 8'd0, 0);
    idle_cycles("t3", 2, 0);
    step("t3j", 0, 8'd0, 0, 1, 8'd2, 1);
    idle_cycles("t3", 8, 1);

    // Last legal address, then out of range.
    step("t4", 1, 8'd127, 0, 0, 8'd0, 1);
    idle_cycles("t4", 6, 1);
    check("t4_err_oob", 32'(err_oob), 32'd1);

    // Restart from HALTED clears err_oob; stop while offering a word.
    step("t5", 1, 8'd0, 0, 0, 8'd0, 0);
    check("t5_err_cleared", 32'(err_oob), 32'd0);
    idle_cycles("t5", 3, 0);
    step("t5s", 0, 8'd0, 1, 0, 8'd0, 0);
    idle_cycles("t5", 3, 1);

    // Asynchronous reset while a word is on offer.
    step("t6", 1, 8'd0, 0, 0, 8'd0, 0);
    idle_cycles("t6", 2, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles("t6_post", 4, 1);

    // Random program and random control traffic.
    for (int i = 0; i < 128; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    for (int c = 0; c < 3000; c++) begin
      step("rnd",
           $urandom_range(0, 5) == 0,
           8'($urandom_range(0, 3) == 0 ? $urandom_range(120, 135) : $urandom_range(0, 127)),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) == 0,
           8'($urandom_range(0, 140)),
           $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_instr_fetch_ctrl
